// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity mode encodings, frame constants and the parity helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Parity bit for a byte: XOR for even, inverted XOR for odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out bundle of the UART transmitter.
// The master supplies bytes; the slave (the transmitter) drives the line.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal
// count. Held at zero while disabled and wraps to zero on the tick.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // 16 bits cover the full legal CLKS_PER_BIT range.
  localparam logic [15:0] TERM = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;

  assign tick = en && (cnt == TERM);

  // Counter advances while enabled, restarts on the tick or when disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// one stop bit. The serial line comes straight from a register.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0
) (
  input  logic        clk,
  input  logic        rst,
  uart_tx_if.slave    bus
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 par_q;
  logic                 tx_q;
  logic                 tx_nxt;
  logic                 tick;
  logic                 timer_en;
  logic                 accept;

  assign accept   = (state == IDLE) && bus.tx_valid;
  assign timer_en = (state != IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (timer_en),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the value the line takes after this edge.
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_q;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (bus.tx_valid) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            if (PARITY != PAR_NONE) begin
              state_nxt = PAR;
              tx_nxt    = par_q;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            // shreg[0] is on the line now; shreg[1] goes out next.
            tx_nxt = shreg[1];
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (tick) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // Byte capture, shifting, bit counting and the registered line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      tx_q <= tx_nxt;
      if (accept) begin
        shreg   <= bus.tx_data;
        bit_idx <= '0;
        par_q   <= parity_bit(bus.tx_data, PARITY);
      end else if ((state == DATA) && tick) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = (state == IDLE);
  assign bus.tx_busy  = (state != IDLE);
  assign bus.tx_done  = (state == STOP) && tick;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no, even, odd parity) share one
// stimulus stream; a frame-level model predicts every output each cycle.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data_s;
  logic       valid_s;
  bit         chk_en;

  int n_cmp;
  int n_bad;

  uart_tx_if u_if0 ();
  uart_tx_if u_if1 ();
  uart_tx_if u_if2 ();

  assign u_if0.tx_data  = data_s;
  assign u_if0.tx_valid = valid_s;
  assign u_if1.tx_data  = data_s;
  assign u_if1.tx_valid = valid_s;
  assign u_if2.tx_data  = data_s;
  assign u_if2.tx_valid = valid_s;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0)) dut0 (.clk(clk), .rst(rst), .bus(u_if0));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1)) dut1 (.clk(clk), .rst(rst), .bus(u_if1));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut2 (.clk(clk), .rst(rst), .bus(u_if2));

  logic tx_w   [3];
  logic rdy_w  [3];
  logic busy_w [3];
  logic done_w [3];

  assign tx_w[0] = u_if0.tx;        assign tx_w[1] = u_if1.tx;        assign tx_w[2] = u_if2.tx;
  assign rdy_w[0] = u_if0.tx_ready; assign rdy_w[1] = u_if1.tx_ready; assign rdy_w[2] = u_if2.tx_ready;
  assign busy_w[0] = u_if0.tx_busy; assign busy_w[1] = u_if1.tx_busy; assign busy_w[2] = u_if2.tx_busy;
  assign done_w[0] = u_if0.tx_done; assign done_w[1] = u_if1.tx_done; assign done_w[2] = u_if2.tx_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // Instance d uses parity mode d (0 none, 1 even, 2 odd).
  bit         m_act  [3];
  int         m_t    [3];
  logic [7:0] m_byte [3];

  function automatic int frame_len(input int d);
    return (d == 0) ? 10 * CPB : 11 * CPB;
  endfunction

  function automatic logic exp_tx(input int d);
    int pos;
    if (!m_act[d]) return 1'b1;
    pos = m_t[d] / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_byte[d][pos-1];
    if (pos == 9 && d == 1) return ^m_byte[d];
    if (pos == 9 && d == 2) return ~(^m_byte[d]);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst) begin
        m_act[d] <= 1'b0;
        m_t[d]   <= 0;
      end else if (m_act[d]) begin
        m_t[d] <= m_t[d] + 1;
        if (m_t[d] + 1 == frame_len(d)) m_act[d] <= 1'b0;
      end else if (valid_s) begin
        m_act[d]  <= 1'b1;
        m_t[d]    <= 0;
        m_byte[d] <= data_s;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        if (!rst) begin
          chk($sformatf("rst_tx%0d", d),   tx_w[d],   1'b1);
          chk($sformatf("rst_rdy%0d", d),  rdy_w[d],  1'b1);
          chk($sformatf("rst_busy%0d", d), busy_w[d], 1'b0);
          chk($sformatf("rst_done%0d", d), done_w[d], 1'b0);
        end else begin
          chk($sformatf("tx%0d", d),   tx_w[d],   exp_tx(d));
          chk($sformatf("rdy%0d", d),  rdy_w[d],  !m_act[d]);
          chk($sformatf("busy%0d", d), busy_w[d], m_act[d]);
          chk($sformatf("done%0d", d), done_w[d], m_act[d] && (m_t[d] == frame_len(d) - 1));
        end
      end
    end
  end

  // ---------------- capture for literal checks ----------------
  logic cap_tx [3][0:99];
  logic cap_done0 [0:99];
  logic cap_rdy0  [0:99];
  logic cap_rdy1  [0:99];

  // Cycle c (1-based) is the cycle after c edges following acceptance.
  task automatic capture(input int n, input bit toggle, input int drop_at);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) cap_tx[d][c] = tx_w[d];
      cap_done0[c] = done_w[0];
      cap_rdy0[c]  = rdy_w[0];
      cap_rdy1[c]  = rdy_w[1];
      if (toggle) data_s = ~data_s;
      if (c == drop_at) valid_s = 1'b0;
    end
  endtask

  function automatic logic [7:0] get_byte(input int d, input int c0);
    logic [7:0] b;
    for (int k = 1; k <= 8; k++) b[k-1] = cap_tx[d][c0 + CPB * k];
    return b;
  endfunction

  task automatic send(input logic [7:0] b, input bit keep_valid);
    @(posedge clk);
    #1;
    valid_s = 1'b1;
    data_s  = b;
    @(posedge clk);
    #1;
    if (!keep_valid) valid_s = 1'b0;
  endtask

  initial begin
    logic [9:0] seq_act;
    logic [9:0] seq_exp;
    int         cnt;
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b0;
    valid_s = 1'b0;
    data_s  = 8'h00;
    chk_en  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset, no valid.
    repeat (50) @(posedge clk);
    #1;
    chk("idle_tx", tx_w[0], 1'b1);
    chk("idle_rdy", rdy_w[0], 1'b1);
    chk("idle_done", done_w[0], 1'b0);

    // Single frame 0xA5.
    send(8'hA5, 1'b0);
    capture(48, 1'b0, 0);
    seq_exp = 10'b1101001010;
    for (int k = 0; k < 10; k++) seq_act[k] = cap_tx[0][CPB * k + 2];
    chk("a5_bits", seq_act, seq_exp);
    cnt = 0;
    for (int c = 1; c <= 48; c++) cnt += int'(cap_done0[c]);
    chk("a5_done_cnt", cnt, 1);
    chk("a5_done_c40", cap_done0[40], 1'b1);
    cnt = 0;
    for (int c = 1; c <= 48; c++) cnt += int'(!cap_rdy0[c]);
    chk("a5_busy_len", cnt, 40);
    chk("a5_even_par", cap_tx[1][38], 1'b0);
    chk("a5_odd_par", cap_tx[2][38], 1'b1);

    // Parity with 0x07.
    send(8'h07, 1'b0);
    capture(48, 1'b0, 0);
    chk("07_even_par", cap_tx[1][38], 1'b1);
    chk("07_odd_par", cap_tx[2][38], 1'b0);
    cnt = 0;
    for (int c = 1; c <= 48; c++) cnt += int'(!cap_rdy1[c]);
    chk("07_par_len", cnt, 44);

    // Back-to-back 0x00 then 0xFF with valid held.
    send(8'h00, 1'b1);
    data_s = 8'hFF;
    capture(90, 1'b0, 50);
    cnt = 0;
    for (int c = 1; c <= 81; c++) cnt += int'(cap_rdy0[c]);
    chk("b2b_gap", cnt, 1);
    chk("b2b_gap_tx", cap_tx[0][41], 1'b1);
    chk("b2b_byte0", get_byte(0, 2), 8'h00);
    chk("b2b_byte1", get_byte(0, 43), 8'hFF);

    // Data toggling during a frame.
    send(8'h3C, 1'b0);
    capture(48, 1'b1, 0);
    chk("tog_byte0", get_byte(0, 2), 8'h3C);
    chk("tog_byte2", get_byte(2, 2), 8'h3C);

    // Reset during DATA bit 3 of 0xA5 (bit 3 is 0).
    data_s = 8'h00;
    send(8'hA5, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    chk("mid_pre_tx", tx_w[0], 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_tx0", tx_w[0], 1'b1);
    chk("mid_tx1", tx_w[1], 1'b1);
    chk("mid_rdy0", rdy_w[0], 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("post_rdy", rdy_w[0], 1'b1);
    chk("post_tx", tx_w[2], 1'b1);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
